// File: rtl/mmio_pkg.sv
// Shared constants for the data-side memory system: MMIO base, register offsets,
// STATUS bit positions and STATUS write-one-to-clear bits.
package mmio_pkg;

  localparam logic [31:0] MMIO_BASE   = 32'h8000_0000;

  localparam logic [1:0]  OFF_TXDATA  = 2'd0;
  localparam logic [1:0]  OFF_STATUS  = 2'd1;
  localparam logic [1:0]  OFF_CYCLE   = 2'd2;
  localparam logic [1:0]  OFF_COMPARE = 2'd3;

  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVF       = 2;
  localparam int ST_IRQ       = 3;
  localparam int ST_COUNT_LSB = 4;

  localparam int CLR_OVF = 0;
  localparam int CLR_IRQ = 1;

endpackage

// File: rtl/data_mem_mmio_if.sv
// Core data bus plus TX stream and timer interrupt of the data memory system.
// Handshake: a TX word transfers on a rising edge where tx_valid & tx_ready; tx_data/tx_valid hold otherwise.
interface data_mem_mmio_if;
  logic        we;
  logic [31:0] a;
  logic [31:0] wd;
  logic [31:0] rd;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        timer_irq;

  modport master (
    output we, a, wd, tx_ready,
    input  rd, tx_data, tx_valid, timer_irq
  );

  modport slave (
    input  we, a, wd, tx_ready,
    output rd, tx_data, tx_valid, timer_irq
  );
endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered-only head output; a push into a full FIFO is
// accepted only when a pop frees the slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [WIDTH-1:0]           head
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign head    = empty ? '0 : mem_q[rd_ptr_q];
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: a cleared count makes stale entries unreachable.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end
endmodule

// File: rtl/data_mem_mmio.sv
// Data memory for the single-cycle core: word RAM below 0x8000_0000, MMIO above
// (TX FIFO, free-running cycle counter, compare-match interrupt). Reads are combinational.
module data_mem_mmio
  import mmio_pkg::*;
#(
  parameter int RAM_WORDS  = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           reset,
  data_mem_mmio_if.slave bus
);
  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam int CW     = $clog2(FIFO_DEPTH+1);

  logic [31:0]       ram_q [RAM_WORDS];
  logic [RAM_AW-1:0] ram_idx;
  logic              mmio_hit;
  logic [1:0]        reg_off;
  logic              wr_tx, wr_status, wr_cycle, wr_cmp;

  logic [31:0] cycle_q, cycle_d;
  logic [31:0] compare_q, compare_d;
  logic        cmp_en_q, cmp_en_d;
  logic        ovf_q, ovf_d;
  logic        irq_q, irq_d;

  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [31:0]   status_word;
  logic          unused_addr_bits;

  assign ram_idx   = bus.a[RAM_AW+1:2];
  assign mmio_hit  = bus.a[31] & (bus.a[30:4] == '0);
  assign reg_off   = bus.a[3:2];
  assign wr_tx     = bus.we & mmio_hit & (reg_off == OFF_TXDATA);
  assign wr_status = bus.we & mmio_hit & (reg_off == OFF_STATUS);
  assign wr_cycle  = bus.we & mmio_hit & (reg_off == OFF_CYCLE);
  assign wr_cmp    = bus.we & mmio_hit & (reg_off == OFF_COMPARE);
  assign unused_addr_bits = ^bus.a[1:0];

  assign fifo_push = wr_tx;
  assign fifo_pop  = bus.tx_ready & ~fifo_empty;

  sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (bus.wd),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .head  (bus.tx_data)
  );

  assign bus.tx_valid  = ~fifo_empty;
  assign bus.timer_irq = irq_q;

  always_comb begin
    status_word = '0;
    status_word[ST_COUNT_LSB +: 4] = 4'(fifo_count);
    status_word[ST_IRQ]   = irq_q;
    status_word[ST_OVF]   = ovf_q;
    status_word[ST_FULL]  = fifo_full;
    status_word[ST_EMPTY] = fifo_empty;
  end

  // Sets are ordered after clears so a same-cycle event wins over software clear;
  // the match compares the pre-load counter value.
  always_comb begin
    cycle_d   = wr_cycle ? bus.wd : cycle_q + 32'd1;
    compare_d = wr_cmp ? bus.wd : compare_q;
    cmp_en_d  = cmp_en_q | wr_cmp;
    ovf_d     = ovf_q;
    irq_d     = irq_q;
    if (wr_status && bus.wd[CLR_OVF]) ovf_d = 1'b0;
    if (wr_status && bus.wd[CLR_IRQ]) irq_d = 1'b0;
    if (fifo_push && fifo_full && !fifo_pop) ovf_d = 1'b1;
    if (cmp_en_q && (cycle_q == compare_q)) irq_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q   <= '0;
      compare_q <= '0;
      cmp_en_q  <= 1'b0;
      ovf_q     <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      cycle_q   <= cycle_d;
      compare_q <= compare_d;
      cmp_en_q  <= cmp_en_d;
      ovf_q     <= ovf_d;
      irq_q     <= irq_d;
    end
  end

  always_ff @(posedge clk) begin
    if (bus.we && !bus.a[31]) ram_q[ram_idx] <= bus.wd;
  end

  always_comb begin
    bus.rd = '0;
    if (!bus.a[31]) begin
      bus.rd = ram_q[ram_idx];
    end else if (mmio_hit) begin
      unique case (reg_off)
        OFF_STATUS:  bus.rd = status_word;
        OFF_CYCLE:   bus.rd = cycle_q;
        OFF_COMPARE: bus.rd = compare_q;
        default:     bus.rd = '0;
      endcase
    end
  end
endmodule
